// File: rtl/mcu_pipe_pkg.sv
// Shared types and constants for the MCU pipeline control unit and its datapath.
// Scoreboard entry control fields, forwarding select encoding and the NOP control word.
package mcu_pipe_pkg;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic valid;
        logic rw;
        logic load;
    } sb_ctl_t;

    localparam sb_ctl_t SB_BUBBLE = '{valid: 1'b0, rw: 1'b0, load: 1'b0};

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic [1:0] bs;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '{rw: 1'b0, mw: 1'b0, bs: 2'd0};

endpackage

// File: rtl/mcu_pipe_ctrl_scoreboard.sv
// Shift register of in-flight register writes, one entry per post-decode stage.
// Emits per-stage RAW match vectors for the A and B operands of the decode stage.
module pipe_scoreboard
    import mcu_pipe_pkg::*;
#(
    parameter int AW    = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cap,
    input  logic             i_rw,
    input  logic [AW-1:0]    i_da,
    input  logic             i_load,
    input  logic [AW-1:0]    i_aa,
    input  logic             i_rd_a,
    input  logic [AW-1:0]    i_ba,
    input  logic             i_rd_b,
    output logic [DEPTH-1:0] o_match_a,
    output logic [DEPTH-1:0] o_match_b,
    output logic [DEPTH-1:0] o_load,
    output logic [DEPTH-1:0] o_valid
);

    sb_ctl_t       r_ctl [DEPTH];
    logic [AW-1:0] r_da  [DEPTH];
    sb_ctl_t       w_in_ctl;

    always_comb begin
        w_in_ctl = SB_BUBBLE;
        if (i_cap) begin
            w_in_ctl = '{valid: 1'b1, rw: i_rw, load: i_load};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctl[i] <= SB_BUBBLE;
            end
        end else begin
            r_ctl[0] <= w_in_ctl;
            for (int i = 1; i < DEPTH; i++) begin
                r_ctl[i] <= r_ctl[i-1];
            end
        end
    end

    // Destination addresses are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        r_da[0] <= i_cap ? i_da : '0;
        for (int i = 1; i < DEPTH; i++) begin
            r_da[i] <= r_da[i-1];
        end
    end

    always_comb begin
        o_match_a = '0;
        o_match_b = '0;
        o_load    = '0;
        o_valid   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            o_match_a[k] = r_ctl[k].valid & r_ctl[k].rw & (r_da[k] == i_aa) & i_rd_a;
            o_match_b[k] = r_ctl[k].valid & r_ctl[k].rw & (r_da[k] == i_ba) & i_rd_b;
            o_load[k]    = r_ctl[k].load;
            o_valid[k]   = r_ctl[k].valid;
        end
    end

endmodule

// File: rtl/mcu_pipe_ctrl.sv
// Pipeline control for the in-order MCU: hazard detection, operand forwarding selects,
// load-use and stall-only modes, branch flush and saturating stall/flush counters.
module mcu_pipe_ctrl
    import mcu_pipe_pkg::*;
#(
    parameter int AW     = 3,
    parameter int DEPTH  = 2,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16,
    localparam int SW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_aa,
    input  logic [AW-1:0]    id_ba,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic             id_rw,
    input  logic [AW-1:0]    id_da,
    input  logic             id_load,
    input  logic             br_taken,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             bubble_ex,
    output logic [SW-1:0]    fwd_a_sel,
    output logic [SW-1:0]    fwd_b_sel,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [DEPTH-1:0] w_match_a;
    logic [DEPTH-1:0] w_match_b;
    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_valid;
    logic             w_hazard;
    logic             w_stall;
    logic             w_cap;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Lowest matching stage is the youngest producer; it must win over older copies.
    function automatic logic [SW-1:0] youngest(input logic [DEPTH-1:0] m);
        logic [SW-1:0] sel;
        sel = SW'(FWD_RF);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (m[k]) sel = SW'(k + 1);
        end
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    pipe_scoreboard #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_sb (
        .clk       (clk),
        .rst       (reset),
        .i_cap     (w_cap),
        .i_rw      (id_rw),
        .i_da      (id_da),
        .i_load    (id_load),
        .i_aa      (id_aa),
        .i_rd_a    (id_valid & id_use_a),
        .i_ba      (id_ba),
        .i_rd_b    (id_valid & id_use_b),
        .o_match_a (w_match_a),
        .o_match_b (w_match_b),
        .o_load    (w_load),
        .o_valid   (w_valid)
    );

    // With forwarding only a load still in EX blocks; without it any in-flight match blocks.
    always_comb begin
        fwd_a_sel = SW'(FWD_RF);
        fwd_b_sel = SW'(FWD_RF);
        w_hazard  = 1'b0;
        if (FWD_EN != 0) begin
            fwd_a_sel = youngest(w_match_a);
            fwd_b_sel = youngest(w_match_b);
            w_hazard  = (w_match_a[0] | w_match_b[0]) & w_load[0];
        end else begin
            w_hazard  = (|w_match_a) | (|w_match_b);
        end
    end

    assign w_stall     = w_hazard & ~br_taken;
    assign w_cap       = id_valid & ~w_stall & ~br_taken;
    assign stall_pc    = w_stall;
    assign stall_if_id = w_stall;
    assign flush_if_id = br_taken;
    assign bubble_ex   = w_stall | br_taken;
    assign stage_valid = w_valid;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall)  r_stall_cnt <= sat_inc(r_stall_cnt);
            if (br_taken) r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

endmodule
